// File: rtl/lif_neuron_if.sv
// Signal bundle between a pre-synaptic driver and the lif_neuron core.
// The neuron uses the slave modport; the stimulus/upstream side uses master.
interface lif_neuron_if #(
  parameter int VMEM_W = 12
);
  logic              en;
  logic [4:0]        pre_spike;
  logic [7:0]        weight;
  logic              post_spike;
  logic [VMEM_W-1:0] vmem;
  logic              refractory;
  logic [7:0]        spike_count;

  modport master (
    output en,
    output pre_spike,
    output weight,
    input  post_spike,
    input  vmem,
    input  refractory,
    input  spike_count
  );

  modport slave (
    input  en,
    input  pre_spike,
    input  weight,
    output post_spike,
    output vmem,
    output refractory,
    output spike_count
  );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a fixed refractory period.
// Optional saturating firing counter is built when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron #(
  parameter int THRESHOLD      = 200,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4,
  parameter int VMEM_W         = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  lif_neuron_if.slave   io_bus
);

  localparam logic [VMEM_W-1:0] LP_THRESH  = VMEM_W'(THRESHOLD);
  localparam logic [7:0]        LP_REFRACT = 8'(REFRACT_CYCLES);

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [VMEM_W-1:0] r_vmem;
  logic [VMEM_W-1:0] w_vmem_nxt;
  logic [7:0]        r_refr_cnt;
  logic [7:0]        w_refr_cnt_nxt;
  logic              w_fire_entry;

  logic [2:0]        w_popcnt;
  logic [10:0]       w_cur;
  logic [VMEM_W-1:0] w_leak;
  logic [VMEM_W:0]   w_sum;
  logic [VMEM_W-1:0] w_sat;
  logic              w_cross;

  always_comb begin
    w_popcnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_popcnt = w_popcnt + {2'b00, io_bus.pre_spike[i]};
    end
  end

  // One extra bit of headroom holds the worst case (full vmem plus 1275) before saturation.
  assign w_cur   = 11'(w_popcnt) * 11'(io_bus.weight);
  assign w_leak  = r_vmem >> LEAK_SHIFT;
  assign w_sum   = {1'b0, r_vmem} - {1'b0, w_leak} + (VMEM_W+1)'(w_cur);
  assign w_sat   = w_sum[VMEM_W] ? {VMEM_W{1'b1}} : w_sum[VMEM_W-1:0];
  assign w_cross = (w_sat >= LP_THRESH);

  always_comb begin
    w_state_nxt    = r_state;
    w_vmem_nxt     = r_vmem;
    w_refr_cnt_nxt = r_refr_cnt;
    w_fire_entry   = 1'b0;
    unique case (r_state)
      ST_INTEGRATE: begin
        if (io_bus.en) begin
          if (w_cross) begin
            w_state_nxt  = ST_FIRE;
            w_vmem_nxt   = '0;
            w_fire_entry = 1'b1;
          end else begin
            w_vmem_nxt = w_sat;
          end
        end
      end
      ST_FIRE: begin
        w_vmem_nxt = '0;
        if (REFRACT_CYCLES == 0) begin
          w_state_nxt    = ST_INTEGRATE;
          w_refr_cnt_nxt = 8'd0;
        end else begin
          w_state_nxt    = ST_REFRACT;
          w_refr_cnt_nxt = LP_REFRACT;
        end
      end
      ST_REFRACT: begin
        // Counter was loaded with the full length, so leaving at 1 gives exactly that many cycles.
        w_vmem_nxt     = '0;
        w_refr_cnt_nxt = (r_refr_cnt == 8'd0) ? 8'd0 : r_refr_cnt - 8'd1;
        if (r_refr_cnt <= 8'd1) begin
          w_state_nxt = ST_INTEGRATE;
        end
      end
      default: begin
        w_state_nxt    = ST_INTEGRATE;
        w_vmem_nxt     = '0;
        w_refr_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INTEGRATE;
      r_vmem     <= '0;
      r_refr_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_vmem     <= w_vmem_nxt;
      r_refr_cnt <= w_refr_cnt_nxt;
    end
  end

  assign io_bus.post_spike = (r_state == ST_FIRE);
  assign io_bus.refractory = (r_state == ST_REFRACT);
  assign io_bus.vmem       = r_vmem;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] r_spike_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_count <= 8'd0;
    end else if (w_fire_entry && (r_spike_count != 8'hFF)) begin
      r_spike_count <= r_spike_count + 8'd1;
    end
  end

  assign io_bus.spike_count = r_spike_count;
`else
  logic w_unused_fire_entry;
  assign w_unused_fire_entry = w_fire_entry;
  assign io_bus.spike_count  = 8'd0;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron: default, saturating-threshold
// and zero-refractory instances share one clock and one reset.
module tb_lif_neuron;

`ifdef LIF_SPIKE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nErrors = 0;

  lif_neuron_if #(.VMEM_W(12)) busD ();
  lif_neuron_if #(.VMEM_W(12)) busS ();
  lif_neuron_if #(.VMEM_W(12)) busR ();

  lif_neuron u_dflt (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (busD)
  );

  lif_neuron #(.THRESHOLD(4095)) u_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (busS)
  );

  lif_neuron #(.REFRACT_CYCLES(0)) u_r0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (busR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int which, input logic en, input logic [4:0] pre,
                               input logic [7:0] w);
    case (which)
      0: begin busD.en = en; busD.pre_spike = pre; busD.weight = w; end
      1: begin busS.en = en; busS.pre_spike = pre; busS.weight = w; end
      default: begin busR.en = en; busR.pre_spike = pre; busR.weight = w; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int nPost;
    int nRefr;

    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 5'b0, 8'd0);
    applyStimulus(1, 1'b0, 5'b0, 8'd0);
    applyStimulus(2, 1'b0, 5'b0, 8'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_vmem",  32'(busD.vmem), 0);
    checkOutput("rst_post",  32'(busD.post_spike), 0);
    checkOutput("rst_refr",  32'(busD.refractory), 0);
    checkOutput("rst_count", 32'(busD.spike_count), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single input at weight 100: 100, 188, then fire.
    applyStimulus(0, 1'b1, 5'b00001, 8'd100);
    tick();
    checkOutput("int1_vmem", 32'(busD.vmem), 100);
    tick();
    checkOutput("int2_vmem", 32'(busD.vmem), 188);
    checkOutput("int2_post", 32'(busD.post_spike), 0);
    tick();
    checkOutput("fire_post", 32'(busD.post_spike), 1);
    checkOutput("fire_vmem", 32'(busD.vmem), 0);
    checkOutput("fire_refr", 32'(busD.refractory), 0);
    checkOutput("fire_count", 32'(busD.spike_count), CNT_EN ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("refr%0d_flag", i), 32'(busD.refractory), 1);
      checkOutput($sformatf("refr%0d_vmem", i), 32'(busD.vmem), 0);
      checkOutput($sformatf("refr%0d_post", i), 32'(busD.post_spike), 0);
    end
    tick();
    checkOutput("reint_refr", 32'(busD.refractory), 0);
    checkOutput("reint_vmem0", 32'(busD.vmem), 0);
    tick();
    checkOutput("reint_vmem", 32'(busD.vmem), 100);

    // Pure leak down to the residue that no longer decays.
    applyStimulus(0, 1'b1, 5'b00000, 8'd100);
    tick();
    checkOutput("leak1", 32'(busD.vmem), 88);
    tick();
    checkOutput("leak2", 32'(busD.vmem), 77);
    tick();
    checkOutput("leak3", 32'(busD.vmem), 68);
    tick();
    checkOutput("leak4", 32'(busD.vmem), 60);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("leak_floor", 32'(busD.vmem), 7);
    tick();
    checkOutput("leak_floor_hold", 32'(busD.vmem), 7);

    // Disabled integration ignores even a saturating input.
    applyStimulus(0, 1'b0, 5'b11111, 8'd255);
    tick();
    tick();
    checkOutput("en0_vmem", 32'(busD.vmem), 7);
    checkOutput("en0_post", 32'(busD.post_spike), 0);

    // Saturating input fires immediately, then every 6 cycles.
    applyStimulus(0, 1'b1, 5'b11111, 8'd255);
    tick();
    checkOutput("sat_fire1", 32'(busD.post_spike), 1);
    nPost = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busD.post_spike === 1'b1) nPost++;
    end
    checkOutput("sat_gap_posts", 32'(nPost), 0);
    tick();
    checkOutput("sat_fire2", 32'(busD.post_spike), 1);
    checkOutput("sat_count", 32'(busD.spike_count), CNT_EN ? 3 : 0);

    // Asynchronous reset in the middle of the refractory period.
    tick();
    checkOutput("pre_rst_refr", 32'(busD.refractory), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_refr",  32'(busD.refractory), 0);
    checkOutput("arst_post",  32'(busD.post_spike), 0);
    checkOutput("arst_vmem",  32'(busD.vmem), 0);
    checkOutput("arst_count", 32'(busD.spike_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_fire", 32'(busD.post_spike), 1);
    checkOutput("post_rst_count", 32'(busD.spike_count), CNT_EN ? 1 : 0);
    applyStimulus(0, 1'b0, 5'b0, 8'd0);

    // Threshold at full scale: 1275, 2391, 3368, then saturated 4095 fires.
    applyStimulus(1, 1'b1, 5'b11111, 8'd255);
    tick();
    checkOutput("thr_v1", 32'(busS.vmem), 1275);
    tick();
    checkOutput("thr_v2", 32'(busS.vmem), 2391);
    tick();
    checkOutput("thr_v3", 32'(busS.vmem), 3368);
    checkOutput("thr_nofire", 32'(busS.post_spike), 0);
    tick();
    checkOutput("thr_fire", 32'(busS.post_spike), 1);
    checkOutput("thr_vmem0", 32'(busS.vmem), 0);
    applyStimulus(1, 1'b0, 5'b0, 8'd0);

    // No refractory period: fire every other cycle.
    applyStimulus(2, 1'b1, 5'b11111, 8'd255);
    tick();
    checkOutput("r0_fire1", 32'(busR.post_spike), 1);
    tick();
    checkOutput("r0_int_post", 32'(busR.post_spike), 0);
    checkOutput("r0_int_refr", 32'(busR.refractory), 0);
    tick();
    checkOutput("r0_fire2", 32'(busR.post_spike), 1);
    nPost = 0;
    nRefr = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (busR.post_spike === 1'b1) nPost++;
      if (busR.refractory !== 1'b0) nRefr++;
    end
    checkOutput("r0_posts", 32'(nPost), 300);
    checkOutput("r0_refr_never", 32'(nRefr), 0);
    checkOutput("r0_count_sat", 32'(busR.spike_count), CNT_EN ? 255 : 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron producing the post-synaptic spike consumed by the STDP weight-update stage. Each cycle it weights the 5-bit pre-synaptic spike vector by the current synaptic weight (fed back from the STDP stage), integrates the result into a leaky membrane potential, and fires a one-cycle `post_spike` when threshold is reached. After firing it enters a fixed refractory period.

## Interface
- `THRESHOLD`, 200: firing threshold; membrane value compared with `>=`; must be in range 1 to 2^VMEM_W-1.
- `LEAK_SHIFT`, 3: leak per integrate cycle is `vmem >> LEAK_SHIFT`; range 1 to VMEM_W-1.
- `REFRACT_CYCLES`, 4: refractory length in cycles; 0 allowed; maximum 255.
- `VMEM_W`, 12: membrane potential width; minimum 11.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: integration enable; only gates the INTEGRATE state.
- `pre_spike` in 5: pre-synaptic spike lines, sampled each cycle.
- `weight` in 8: unsigned synaptic weight applied to every active pre_spike bit.
- `post_spike` out 1: high for exactly one cycle per firing.
- `vmem` out VMEM_W: registered membrane potential.
- `refractory` out 1: high while in REFRACT.
- `spike_count` out 8: saturating firing counter; see Configuration.

## Operation
- States: INTEGRATE, FIRE, REFRACT. Reset state is INTEGRATE.
- Input current: `cur = popcount(pre_spike) * weight`, 11 bits unsigned, maximum 1275.
- INTEGRATE with `en=1`:
  - `sum = vmem - (vmem >> LEAK_SHIFT) + cur`, computed at VMEM_W+1 bits.
  - `sum` saturates to 2^VMEM_W-1.
  - If the saturated sum is `>= THRESHOLD`: go to FIRE and set `vmem <= 0`.
  - Otherwise set `vmem <=` the saturated sum.
- INTEGRATE with `en=0`: vmem and state hold; inputs are ignored.
- Leak rounds toward zero. When `vmem < 2^LEAK_SHIFT` the leak is 0, so a sub-threshold residue persists.
- FIRE lasts one cycle regardless of `en`.
  - `post_spike` is 1 and `vmem` is 0.
  - Inputs are ignored.
  - Next state is REFRACT with counter loaded to REFRACT_CYCLES, or INTEGRATE if REFRACT_CYCLES=0.
- REFRACT, regardless of `en`:
  - `refractory` is 1, `vmem` holds at 0, inputs are ignored.
  - The counter decrements every cycle; when it reaches 0 the next state is INTEGRATE.
  - REFRACT therefore lasts exactly REFRACT_CYCLES cycles.
- `post_spike` and `refractory` are decoded directly from registered state, with no combinational path from inputs.

## Timing
- Reset values: `vmem`=0, `post_spike`=0, `refractory`=0, `spike_count`=0, state INTEGRATE, refractory counter 0.
- Reset assertion clears state immediately (asynchronous), including mid-FIRE or mid-REFRACT. Operation resumes on the first rising edge after deassertion.
- Latency: `pre_spike`/`weight` sampled at edge k causes `post_spike` high from edge k to edge k+1.
- Minimum firing period: 1 + REFRACT_CYCLES + 1 cycles.
- Input changes during FIRE or REFRACT have no effect on later behaviour.
- If `en` falls in the same cycle as a crossing, no crossing is evaluated.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined:
  - `spike_count` increments on every entry into FIRE and saturates at 255.
  - It is cleared only by reset.
- `LIF_SPIKE_COUNT_EN` undefined: `spike_count` is tied to 0 and no counter register is built.

## Test plan
- Defaults; `pre_spike`=5'b00001, `weight`=100, `en`=1 held -> `vmem` 100, then 188, then FIRE (`post_spike`=1, `vmem`=0) on the third edge; then `refractory`=1 for exactly 4 cycles; then integration restarts at 100.
- Defaults; `pre_spike`=5'b11111, `weight`=255 -> `post_spike` after the first edge; with the input held, spikes repeat every 6 cycles.
- Leak only: reach `vmem`=100, then `pre_spike`=0 -> `vmem` 88, 77, 68, 60, ... and stays at 7 once below 8; `en`=0 holds `vmem` unchanged.
- `THRESHOLD`=4095, `pre_spike`=5'b11111, `weight`=255 -> `vmem` 1275, 2391, 3368, then sum 4222 saturates to 4095 and fires.
- `REFRACT_CYCLES`=0 -> FIRE is followed directly by INTEGRATE; `refractory` never asserts; firing period is 2 cycles with saturating input.
- Assert `rst_n` low mid-REFRACT -> all outputs are 0 immediately.
  - With `LIF_SPIKE_COUNT_EN`: 300 firings give `spike_count`=255.
  - Without it: `spike_count` stays 0.
